// File: rtl/step_counter.sv
// Timestep / refractory counter: up/down, programmable limit, wrap or saturate,
// synchronous init/load, enable prescaler and terminal-event status.
module step_counter #(
    parameter int                WIDTH   = 8,
    parameter logic [WIDTH-1:0]  INIT    = {WIDTH{1'b0}},
    parameter int                PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               en,
    input  logic               dir,
    input  logic               sat,
    input  logic [WIDTH-1:0]   limit,
    input  logic [PRESC_W-1:0] presc,
    input  logic               clr_ovf,
    output logic [WIDTH-1:0]   out,
    output logic               tc,
    output logic               wrap_p,
    output logic               ovf
);

    logic [WIDTH-1:0]   out_r;
    logic [PRESC_W-1:0] pc_r;
    logic               wrap_r;
    logic               ovf_r;

    logic [WIDTH-1:0]   out_nxt_s;
    logic [PRESC_W-1:0] pc_nxt_s;
    logic               step_s;
    logic               event_s;
    logic               ovf_nxt_s;

    // Prescaler: init > load > en; '>=' keeps a lowered presc from stalling.
    always_comb begin
        pc_nxt_s = pc_r;
        step_s   = 1'b0;
        if (init || load) begin
            pc_nxt_s = {PRESC_W{1'b0}};
        end else if (en) begin
            if (pc_r >= presc) begin
                pc_nxt_s = {PRESC_W{1'b0}};
                step_s   = 1'b1;
            end else begin
                pc_nxt_s = pc_r + {{(PRESC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Counter next value and terminal-event detection.
    always_comb begin
        out_nxt_s = out_r;
        event_s   = 1'b0;
        if (init) begin
            out_nxt_s = INIT;
        end else if (load) begin
            out_nxt_s = load_val;
        end else if (step_s) begin
            if (dir) begin
                if (out_r < limit) begin
                    out_nxt_s = out_r + {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    event_s   = 1'b1;
                    out_nxt_s = sat ? limit : {WIDTH{1'b0}};
                end
            end else begin
                if (out_r != {WIDTH{1'b0}}) begin
                    out_nxt_s = out_r - {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    event_s   = 1'b1;
                    out_nxt_s = sat ? {WIDTH{1'b0}} : limit;
                end
            end
        end else begin
            out_nxt_s = out_r;
        end
    end

    // Sticky overflow: init clears, a terminal event beats clr_ovf.
    always_comb begin
        ovf_nxt_s = ovf_r;
        if (init) begin
            ovf_nxt_s = 1'b0;
        end else if (event_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r  <= {WIDTH{1'b0}};
            pc_r   <= {PRESC_W{1'b0}};
            wrap_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            out_r  <= out_nxt_s;
            pc_r   <= pc_nxt_s;
            wrap_r <= event_s;
            ovf_r  <= ovf_nxt_s;
        end
    end

    assign out    = out_r;
    assign wrap_p = wrap_r;
    assign ovf    = ovf_r;
    assign tc     = dir ? (out_r >= limit) : (out_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_step_counter.sv
// Directed, table-driven bench for step_counter (WIDTH=8, INIT=3, PRESC_W=4).
module tb_step_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init, load, en, dir, sat, clr_ovf;
    logic [7:0] load_val, limit;
    logic [3:0] presc;
    logic [7:0] out;
    logic       tc, wrap_p, ovf;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       init;
        logic       load;
        logic [7:0] load_val;
        logic       en;
        logic       dir;
        logic       sat;
        logic [7:0] limit;
        logic [3:0] presc;
        logic       clr_ovf;
        logic [7:0] e_out;
        logic       e_tc;
        logic       e_wrap;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    step_counter #(.WIDTH(8), .INIT(8'd3), .PRESC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .sat(sat), .limit(limit), .presc(presc),
        .clr_ovf(clr_ovf), .out(out), .tc(tc), .wrap_p(wrap_p), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic i, input logic l, input logic [7:0] lv,
                                input logic e, input logic d, input logic s,
                                input logic [7:0] lim, input logic [3:0] p,
                                input logic c, input logic [7:0] eo,
                                input logic et, input logic ew, input logic ev);
        vec_t v;
        v.init = i; v.load = l; v.load_val = lv; v.en = e; v.dir = d; v.sat = s;
        v.limit = lim; v.presc = p; v.clr_ovf = c;
        v.e_out = eo; v.e_tc = et; v.e_wrap = ew; v.e_ovf = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] eo, input logic et,
                           input logic ew, input logic ev);
        chk({name, ".out"}, out, eo);
        chk({name, ".tc"}, {7'd0, tc}, {7'd0, et});
        chk({name, ".wrap_p"}, {7'd0, wrap_p}, {7'd0, ew});
        chk({name, ".ovf"}, {7'd0, ovf}, {7'd0, ev});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        init = 1'b0; load = 1'b0; en = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; idle(); load_val = 8'd0; dir = 1'b1; sat = 1'b0;
        limit = 8'd5; presc = 4'd0;
        #12;
        chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Up/wrap, limit 5
        vecs.push_back(mk(0,0,8'd0,1,1,0,8'd5,4'd0,0, 8'd1,0,0,0));
        vecs.push_back(mk(0,0,8'd0,1,1,0,8'd5,4'd0,0, 8'd2,0,0,0));
        vecs.push_back(mk(0,0,8'd0,1,1,0,8'd5,4'd0,0, 8'd3,0,0,0));
        vecs.push_back(mk(0,0,8'd0,1,1,0,8'd5,4'd0,0, 8'd4,0,0,0));
        vecs.push_back(mk(0,0,8'd0,1,1,0,8'd5,4'd0,0, 8'd5,1,0,0));
        vecs.push_back(mk(0,0,8'd0,1,1,0,8'd5,4'd0,0, 8'd0,0,1,1));
        vecs.push_back(mk(0,0,8'd0,1,1,0,8'd5,4'd0,0, 8'd1,0,0,1));
        // Down/saturate from load 2 (en ignored under load)
        vecs.push_back(mk(0,1,8'd2,1,0,1,8'd5,4'd0,0, 8'd2,0,0,1));
        vecs.push_back(mk(0,0,8'd0,1,0,1,8'd5,4'd0,0, 8'd1,0,0,1));
        vecs.push_back(mk(0,0,8'd0,1,0,1,8'd5,4'd0,0, 8'd0,1,0,1));
        vecs.push_back(mk(0,0,8'd0,0,0,1,8'd5,4'd0,1, 8'd0,1,0,0));
        vecs.push_back(mk(0,0,8'd0,1,0,1,8'd5,4'd0,0, 8'd0,1,1,1));
        vecs.push_back(mk(0,0,8'd0,1,0,1,8'd5,4'd0,1, 8'd0,1,1,1));
        vecs.push_back(mk(0,0,8'd0,0,0,1,8'd5,4'd0,0, 8'd0,1,0,1));
        // Priority: init > load > en
        vecs.push_back(mk(1,1,8'd9,1,1,0,8'd5,4'd0,0, 8'd3,0,0,0));
        vecs.push_back(mk(0,1,8'd9,1,1,0,8'd5,4'd0,0, 8'd9,1,0,0));
        // Value above limit: wrap, then saturate clamps
        vecs.push_back(mk(0,0,8'd0,1,1,0,8'd5,4'd0,0, 8'd0,0,1,1));
        vecs.push_back(mk(0,1,8'd9,0,1,1,8'd5,4'd0,0, 8'd9,1,0,1));
        vecs.push_back(mk(0,0,8'd0,1,1,1,8'd5,4'd0,0, 8'd5,1,1,1));
        vecs.push_back(mk(0,0,8'd0,1,1,1,8'd5,4'd0,0, 8'd5,1,1,1));
        // limit 0 up, then down/wrap at 0 reloads limit
        vecs.push_back(mk(0,1,8'd3,0,1,0,8'd0,4'd0,0, 8'd3,1,0,1));
        vecs.push_back(mk(0,0,8'd0,1,1,0,8'd0,4'd0,0, 8'd0,1,1,1));
        vecs.push_back(mk(0,0,8'd0,1,0,0,8'd7,4'd0,0, 8'd7,0,1,1));
        vecs.push_back(mk(0,0,8'd0,1,0,0,8'd7,4'd0,0, 8'd6,0,0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            init = vecs[i].init; load = vecs[i].load; load_val = vecs[i].load_val;
            en = vecs[i].en; dir = vecs[i].dir; sat = vecs[i].sat;
            limit = vecs[i].limit; presc = vecs[i].presc; clr_ovf = vecs[i].clr_ovf;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_tc,
                    vecs[i].e_wrap, vecs[i].e_ovf);
        end

        // Prescaler: presc 2, then lowered to 0 while pc = 2
        idle(); load = 1'b1; load_val = 8'd0; dir = 1'b1; sat = 1'b0;
        limit = 8'd200; presc = 4'd2;
        tick();
        load = 1'b0; en = 1'b1;
        begin
            logic [7:0] pexp [8];
            pexp[0] = 8'd0; pexp[1] = 8'd0; pexp[2] = 8'd1; pexp[3] = 8'd1;
            pexp[4] = 8'd1; pexp[5] = 8'd2; pexp[6] = 8'd2; pexp[7] = 8'd2;
            for (int k = 0; k < 8; k++) begin
                tick();
                chk($sformatf("presc%0d", k), out, pexp[k]);
            end
        end
        presc = 4'd0;
        tick();
        chk("presc_lowered", out, 8'd3);
        tick();
        chk("presc_zero", out, 8'd4);

        // Reset mid-count: reach out=37 with wrap_p=1 and ovf=1
        idle(); load = 1'b1; load_val = 8'd40; limit = 8'd37; sat = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        chk_all("pre_rst", 8'd37, 1'b1, 1'b1, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
        limit = 8'd200; sat = 1'b0; presc = 4'd1;
        #2 rst_n = 1'b1;
        tick();
        chk("rst_pc_discard", out, 8'd0);
        tick();
        chk("rst_resume", out, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
